eproc_out_gearbox: RTL and testbench

EPROC_OUT_GEARBOX -- requirements
Module: eproc_out_gearbox

---
 rtl/eproc_out_gearbox.sv | 110 +++++++++++
 tb/tb_eproc_out_gearbox.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/eproc_out_gearbox.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | eproc_out_gearbox : symbol FIFO feeding a 10-to-ELINK_W serialiser with  |
// |                     idle-symbol insertion when the FIFO runs dry.        |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module eproc_out_gearbox #(
    parameter int         ELINK_W    = 2,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [9:0] IDLE_SYM   = 10'b0011111010
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [9:0]                  sym_in,
    input  logic                        sym_valid,
    output logic                        sym_ready,
    input  logic                        reverse_10b,
    input  logic                        swap_outbits,
    output logic [ELINK_W-1:0]          edata_out,
    output logic                        idle_ins,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);

    generate
        if (!(ELINK_W == 2 || ELINK_W == 4 || ELINK_W == 8)) begin : g_bad_elink_w
            $error("eproc_out_gearbox: ELINK_W must be 2, 4 or 8");
        end
        if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("eproc_out_gearbox: FIFO_DEPTH must be a power of two in 2..16");
        end
    endgenerate

    logic [9:0]         mem_q [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [AW:0]        level_q, level_d;
    logic [17:0]        gbuf_q, gbuf_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [ELINK_W-1:0] edata_d;
    logic               idle_d;

    logic               push, pop, load, fifo_has;
    logic [9:0]         sym_sel, sym_ld;
    logic [17:0]        gbuf_ld;
    logic [4:0]         cnt_ld;

    assign sym_ready  = (level_q != (AW+1)'(FIFO_DEPTH));
    assign fifo_level = level_q;

    always_comb begin
        push     = sym_valid && sym_ready;
        fifo_has = (level_q != '0);
        load     = (cnt_q < 5'(ELINK_W));
        pop      = load && fifo_has;
        // Level is the registered count, so a symbol pushed this edge cannot pop yet.
        sym_sel  = fifo_has ? mem_q[rd_ptr_q] : IDLE_SYM;
        sym_ld   = '0;
        for (int i = 0; i < 10; i++) begin
            sym_ld[i] = reverse_10b ? sym_sel[9-i] : sym_sel[i];
        end

        gbuf_ld = gbuf_q;
        cnt_ld  = cnt_q;
        if (load) begin
            gbuf_ld = gbuf_q | ({8'd0, sym_ld} << cnt_q);
            cnt_ld  = cnt_q + 5'd10;
        end

        gbuf_d  = gbuf_ld >> ELINK_W;
        cnt_d   = cnt_ld - 5'(ELINK_W);
        edata_d = '0;
        for (int i = 0; i < ELINK_W; i++) begin
            edata_d[i] = swap_outbits ? gbuf_ld[ELINK_W-1-i] : gbuf_ld[i];
        end
        idle_d  = load && !fifo_has;
        level_d = level_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= sym_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            gbuf_q    <= '0;
            cnt_q     <= '0;
            edata_out <= '0;
            idle_ins  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + (AW)'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + (AW)'(1);
            end
            level_q   <= level_d;
            gbuf_q    <= gbuf_d;
            cnt_q     <= cnt_d;
            edata_out <= edata_d;
            idle_ins  <= idle_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_eproc_out_gearbox.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_eproc_out_gearbox : directed self-checking bench, three widths.       |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_eproc_out_gearbox;
    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] sym_in;
    logic       sym_valid, rev, swp;

    logic       rdy2, rdy4, rdy8;
    logic [1:0] ed2;
    logic [3:0] ed4;
    logic [7:0] ed8;
    logic       idle2, idle4, idle8;
    logic [2:0] lvl2, lvl4, lvl8;

    int n_cmp = 0;
    int n_bad = 0;

    logic [1:0]   idle_pat [5] = '{2'b10, 2'b10, 2'b11, 2'b11, 2'b00};
    logic [1:0]   ridle_pat[5] = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b01};
    logic [1:0]   swap_pat [5] = '{2'b01, 2'b01, 2'b11, 2'b11, 2'b00};
    logic [2:0]   lvl4_tab [8] = '{3'd1, 3'd2, 3'd1, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0};
    logic         idl4_tab [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [2:0]   lvl8_tab [25] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd3,
                                    3'd3, 3'd3, 3'd3, 3'd3, 3'd4, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4,
                                    3'd3, 3'd3, 3'd3, 3'd3, 3'd4};
    logic [31:0]  stream4;
    logic [199:0] stream8;
    logic [9:0]   data;
    logic         r8;

    always #5 clk = ~clk;

    eproc_out_gearbox #(.ELINK_W(2), .FIFO_DEPTH(4)) u2 (
        .clk(clk), .rst(rst), .sym_in(sym_in), .sym_valid(sym_valid), .sym_ready(rdy2),
        .reverse_10b(rev), .swap_outbits(swp), .edata_out(ed2), .idle_ins(idle2), .fifo_level(lvl2));
    eproc_out_gearbox #(.ELINK_W(4), .FIFO_DEPTH(4)) u4 (
        .clk(clk), .rst(rst), .sym_in(sym_in), .sym_valid(sym_valid), .sym_ready(rdy4),
        .reverse_10b(rev), .swap_outbits(swp), .edata_out(ed4), .idle_ins(idle4), .fifo_level(lvl4));
    eproc_out_gearbox #(.ELINK_W(8), .FIFO_DEPTH(4)) u8 (
        .clk(clk), .rst(rst), .sym_in(sym_in), .sym_valid(sym_valid), .sym_ready(rdy8),
        .reverse_10b(rev), .swap_outbits(swp), .edata_out(ed8), .idle_ins(idle8), .fifo_level(lvl8));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; sym_in = '0; sym_valid = 1'b0; rev = 1'b0; swp = 1'b0;
        #2;
        chk("rst_ed2", 32'(ed2), 0);
        chk("rst_idle2", 32'(idle2), 0);
        chk("rst_lvl2", 32'(lvl2), 0);
        chk("rst_rdy2", 32'(rdy2), 1);
        @(negedge clk);
        rst = 1'b0;

        // W=2 idle pattern, then reversed idle, reversed data symbol and swap
        for (int e = 1; e <= 10; e++) begin
            tick();
            chk($sformatf("A_ed_e%0d", e), 32'(ed2), 32'(idle_pat[(e-1)%5]));
            chk($sformatf("A_idle_e%0d", e), 32'(idle2), 32'((e % 5) == 1));
        end
        rev = 1'b1; sym_valid = 1'b1; sym_in = 10'b0000000001;
        for (int e = 11; e <= 15; e++) begin
            tick();
            sym_valid = 1'b0;
            chk($sformatf("A_ed_e%0d", e), 32'(ed2), 32'(ridle_pat[e-11]));
            chk($sformatf("A_idle_e%0d", e), 32'(idle2), 32'(e == 11));
            chk($sformatf("A_lvl_e%0d", e), 32'(lvl2), 1);
        end
        for (int e = 16; e <= 20; e++) begin
            tick();
            rev = 1'b0;
            chk($sformatf("A_ed_e%0d", e), 32'(ed2), (e == 20) ? 32'h2 : 32'h0);
            chk($sformatf("A_idle_e%0d", e), 32'(idle2), 0);
            chk($sformatf("A_lvl_e%0d", e), 32'(lvl2), 0);
        end
        swp = 1'b1;
        for (int e = 21; e <= 25; e++) begin
            tick();
            chk($sformatf("A_swp_e%0d", e), 32'(ed2), 32'(swap_pat[e-21]));
            chk($sformatf("A_idle_e%0d", e), 32'(idle2), 32'(e == 21));
        end
        swp = 1'b0;

        // W=4 back-to-back pair into an empty FIFO
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("B_rst_ed4", 32'(ed4), 0);
        chk("B_rst_lvl4", 32'(lvl4), 0);
        chk("B_rst_rdy4", 32'(rdy4), 1);
        sym_in = 10'h155; sym_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            if (e == 1) sym_in = 10'h2AA;
            if (e == 2) sym_valid = 1'b0;
            stream4[4*(e-1) +: 4] = ed4;
            chk($sformatf("B_lvl_e%0d", e), 32'(lvl4), 32'(lvl4_tab[e-1]));
            chk($sformatf("B_idle_e%0d", e), 32'(idle4), 32'(idl4_tab[e-1]));
        end
        chk("B_stream", stream4, {2'b10, 10'h2AA, 10'h155, 10'h0FA});

        // W=8 sustained push with incrementing data until back-pressure
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("C_rst_ed8", 32'(ed8), 0);
        chk("C_rst_lvl8", 32'(lvl8), 0);
        data = 10'd1; sym_in = 10'd1; sym_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int e = 1; e <= 25; e++) begin
            r8 = rdy8;
            tick();
            if (r8) begin
                data   = data + 10'd1;
                sym_in = data;
            end
            stream8[8*(e-1) +: 8] = ed8;
            chk($sformatf("C_lvl_e%0d", e), 32'(lvl8), 32'(lvl8_tab[e-1]));
            chk($sformatf("C_rdy_e%0d", e), 32'(rdy8), 32'(lvl8_tab[e-1] != 3'd4));
            chk($sformatf("C_idle_e%0d", e), 32'(idle8), 32'(e == 1));
        end
        sym_valid = 1'b0;
        chk("C_lead_idle", 32'(stream8[9:0]), 32'h0FA);
        for (int k = 1; k <= 19; k++) begin
            chk($sformatf("C_sym%0d", k), 32'(stream8[10*k +: 10]), 32'(k));
        end

        // W=2 asynchronous reset with three symbols queued
        @(negedge clk);
        rst = 1'b1;
        sym_in = 10'h3C3; sym_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tick();
        tick();
        tick();
        sym_valid = 1'b0;
        chk("D_pre_lvl2", 32'(lvl2), 3);
        chk("D_pre_ed2", 32'(ed2), 32'h3);
        #2;
        rst = 1'b1;
        #1;
        chk("D_async_ed2", 32'(ed2), 0);
        chk("D_async_lvl2", 32'(lvl2), 0);
        chk("D_async_idle2", 32'(idle2), 0);
        chk("D_async_rdy2", 32'(rdy2), 1);
        @(negedge clk);
        rst = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            chk($sformatf("D_ed_e%0d", e), 32'(ed2), 32'(idle_pat[(e-1)%5]));
            chk($sformatf("D_idle_e%0d", e), 32'(idle2), 32'((e % 5) == 1));
            chk($sformatf("D_lvl_e%0d", e), 32'(lvl2), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
